// File: rtl/multi_motor_drive.sv
// Multi-channel H-bridge driver with a shared PWM counter, per-channel duty
// ramping, dead-time protected direction reversal and a debounced estop input.
module multi_motor_drive #(
    parameter int NUM_CH          = 4,
    parameter int PWM_PERIOD      = 5000,
    parameter int MAX_POSITION    = 200,
    parameter int RAMP_STEP       = 4,
    parameter int DEAD_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int DUTY_W         = $clog2(MAX_POSITION + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DUTY_W-1:0] speed_cmd,
    input  logic [NUM_CH-1:0]        dir_cmd,
    input  logic                     cmd_valid,
    input  logic                     reed_in,
    output logic [NUM_CH-1:0]        motor_in1,
    output logic [NUM_CH-1:0]        motor_in2,
    output logic [NUM_CH-1:0]        motor_en,
    output logic [NUM_CH-1:0]        busy,
    output logic                     estop_active
);

    localparam int SCALE  = PWM_PERIOD / MAX_POSITION;
    localparam int PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(MAX_POSITION);
    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DECEL,
        DEAD
    } ch_state_t;

    logic [PWM_W-1:0] pwm_cnt;
    logic             tick;
    logic             reed_meta;
    logic             reed_sync;
    logic [DB_W-1:0]  db_cnt;
    logic             estop_db;

    // Last count of the PWM period; duty ramp steps happen on this cycle.
    assign tick = (pwm_cnt == PWM_W'(PWM_PERIOD - 1));

    // Shared PWM period counter, free running across all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous reed contact.
    always_ff @(posedge clk) begin
        if (rst) begin
            reed_meta <= 1'b0;
            reed_sync <= 1'b0;
        end else begin
            reed_meta <= reed_in;
            reed_sync <= reed_meta;
        end
    end

    // Debounce: the level flips only after a full run of differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            estop_db <= 1'b0;
        end else if (reed_sync == estop_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            estop_db <= reed_sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign estop_active = estop_db;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t         state_q;
        ch_state_t         state_d;
        logic [DUTY_W-1:0] cur_q;
        logic [DUTY_W-1:0] cur_d;
        logic [DUTY_W-1:0] tgt_q;
        logic [DUTY_W-1:0] tgt_d;
        logic              tgt_dir_q;
        logic              tgt_dir_d;
        logic              app_dir_q;
        logic              app_dir_d;
        logic [DEAD_W-1:0] dead_q;
        logic [DEAD_W-1:0] dead_d;
        logic              en_q;
        logic              en_d;
        logic [DUTY_W-1:0] speed_raw;
        logic [DUTY_W-1:0] speed_clamped;
        logic [31:0]       on_time;
        logic              driving;

        assign speed_raw     = speed_cmd[g*DUTY_W +: DUTY_W];
        assign speed_clamped = (speed_raw > MAX_D) ? MAX_D : speed_raw;
        assign on_time       = 32'(cur_q) * 32'(SCALE);
        assign en_d          = !estop_db && (32'(pwm_cnt) < on_time);

        // Channel state and datapath registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                cur_q     <= '0;
                tgt_q     <= '0;
                tgt_dir_q <= 1'b0;
                app_dir_q <= 1'b0;
                dead_q    <= '0;
                en_q      <= 1'b0;
            end else begin
                state_q   <= state_d;
                cur_q     <= cur_d;
                tgt_q     <= tgt_d;
                tgt_dir_q <= tgt_dir_d;
                app_dir_q <= app_dir_d;
                dead_q    <= dead_d;
                en_q      <= en_d;
            end
        end

        // Next state: ramping, reversal through DECEL/DEAD, estop override.
        // Transitions read the registered target, so a new command only
        // takes effect one cycle after it is latched.
        always_comb begin
            state_d   = state_q;
            cur_d     = cur_q;
            tgt_d     = tgt_q;
            tgt_dir_d = tgt_dir_q;
            app_dir_d = app_dir_q;
            dead_d    = dead_q;

            if (estop_db) begin
                state_d = IDLE;
                cur_d   = '0;
                tgt_d   = '0;
                dead_d  = '0;
            end else begin
                if (cmd_valid) begin
                    tgt_d     = speed_clamped;
                    tgt_dir_d = dir_cmd[g];
                end

                case (state_q)
                    IDLE: begin
                        cur_d = '0;
                        if (tgt_q != '0) begin
                            app_dir_d = tgt_dir_q;
                            state_d   = RUN;
                        end
                    end
                    RUN: begin
                        if (tgt_q == '0 && cur_q == '0) begin
                            state_d = IDLE;
                        end else if (tgt_dir_q != app_dir_q) begin
                            state_d = DECEL;
                        end else if (tick) begin
                            if (cur_q < tgt_q) begin
                                cur_d = (tgt_q - cur_q > STEP_D) ? cur_q + STEP_D : tgt_q;
                            end else if (cur_q > tgt_q) begin
                                cur_d = (cur_q - tgt_q > STEP_D) ? cur_q - STEP_D : tgt_q;
                            end
                        end
                    end
                    DECEL: begin
                        if (tgt_dir_q == app_dir_q) begin
                            state_d = RUN;
                        end else if (cur_q == '0) begin
                            state_d = DEAD;
                            dead_d  = '0;
                        end else if (tick) begin
                            cur_d = (cur_q > STEP_D) ? cur_q - STEP_D : '0;
                        end
                    end
                    DEAD: begin
                        if (dead_q == DEAD_W'(DEAD_CYCLES - 1)) begin
                            dead_d = '0;
                            if (tgt_q == '0) begin
                                state_d = IDLE;
                            end else begin
                                app_dir_d = tgt_dir_q;
                                state_d   = RUN;
                            end
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cur_d   = '0;
                    end
                endcase
            end
        end

        assign driving      = (state_q == RUN) || (state_q == DECEL);
        assign motor_in1[g] = driving && app_dir_q;
        assign motor_in2[g] = driving && !app_dir_q;
        assign motor_en[g]  = en_q;
        assign busy[g]      = (state_q == DECEL) || (state_q == DEAD) ||
                              ((state_q == RUN) && (cur_q != tgt_q));
    end

endmodule

// File: tb/tb_multi_motor_drive.sv
// Scoreboard bench for multi_motor_drive: a cycle-level reference model pushes
// expected outputs into a queue, a monitor pops and compares every cycle, and
// a few directed checks measure PWM on-time, dead time and estop latency.
module tb_multi_motor_drive;

    localparam int NUM_CH          = 2;
    localparam int PWM_PERIOD      = 20;
    localparam int MAX_POSITION    = 10;
    localparam int RAMP_STEP       = 2;
    localparam int DEAD_CYCLES     = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int DUTY_W          = 4;
    localparam int SCALE           = PWM_PERIOD / MAX_POSITION;

    localparam int OFF   = 0;
    localparam int DRIVE = 1;
    localparam int BRAKE = 2;
    localparam int GAP   = 3;

    logic                     clk       = 1'b0;
    logic                     rst       = 1'b1;
    logic [NUM_CH*DUTY_W-1:0] speed_cmd = '0;
    logic [NUM_CH-1:0]        dir_cmd   = '0;
    logic                     cmd_valid = 1'b0;
    logic                     reed_in   = 1'b0;
    logic [NUM_CH-1:0]        motor_in1;
    logic [NUM_CH-1:0]        motor_in2;
    logic [NUM_CH-1:0]        motor_en;
    logic [NUM_CH-1:0]        busy;
    logic                     estop_active;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];
    int         win_q[$];
    int         win_acc = 0;

    // Reference model state: PWM phase derived from cycles since reset,
    // dead time as a countdown, debounce as a run length of differing samples.
    int m_since = 0;
    int m_pwm   = 0;
    bit m_r1    = 0;
    bit m_r2    = 0;
    bit m_db    = 0;
    int m_run   = 0;
    int m_mode[NUM_CH];
    int m_duty[NUM_CH];
    int m_tgt[NUM_CH];
    int m_tdir[NUM_CH];
    int m_adir[NUM_CH];
    int m_gap[NUM_CH];
    bit m_en[NUM_CH];

    multi_motor_drive #(
        .NUM_CH         (NUM_CH),
        .PWM_PERIOD     (PWM_PERIOD),
        .MAX_POSITION   (MAX_POSITION),
        .RAMP_STEP      (RAMP_STEP),
        .DEAD_CYCLES    (DEAD_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .speed_cmd   (speed_cmd),
        .dir_cmd     (dir_cmd),
        .cmd_valid   (cmd_valid),
        .reed_in     (reed_in),
        .motor_in1   (motor_in1),
        .motor_in2   (motor_in2),
        .motor_en    (motor_en),
        .busy        (busy),
        .estop_active(estop_active)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int s0, input bit d0, input int s1, input bit d1);
        speed_cmd = {4'(s1), 4'(s0)};
        dir_cmd   = {d1, d0};
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic countEn(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cnt += int'(motor_en[ch]);
        end
    endtask

    // One clock of the reference model, evaluated on the rising edge.
    task automatic stepModel();
        int pwm_pre;
        bit tick;
        int delta;
        int spd;
        logic [8:0] e;
        if (rst) begin
            m_since = 0;
            m_r1    = 0;
            m_r2    = 0;
            m_db    = 0;
            m_run   = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_mode[ch] = OFF;
                m_duty[ch] = 0;
                m_tgt[ch]  = 0;
                m_tdir[ch] = 0;
                m_adir[ch] = 0;
                m_gap[ch]  = 0;
                m_en[ch]   = 0;
            end
        end else begin
            pwm_pre = m_since % PWM_PERIOD;
            tick    = (pwm_pre == PWM_PERIOD - 1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (m_db) begin
                    m_en[ch]   = 0;
                    m_mode[ch] = OFF;
                    m_duty[ch] = 0;
                    m_tgt[ch]  = 0;
                    m_gap[ch]  = 0;
                end else begin
                    m_en[ch] = (pwm_pre < m_duty[ch] * SCALE);
                    case (m_mode[ch])
                        OFF: begin
                            m_duty[ch] = 0;
                            if (m_tgt[ch] > 0) begin
                                m_adir[ch] = m_tdir[ch];
                                m_mode[ch] = DRIVE;
                            end
                        end
                        DRIVE: begin
                            if (m_tgt[ch] == 0 && m_duty[ch] == 0) begin
                                m_mode[ch] = OFF;
                            end else if (m_tdir[ch] != m_adir[ch]) begin
                                m_mode[ch] = BRAKE;
                            end else if (tick) begin
                                delta = m_tgt[ch] - m_duty[ch];
                                if (delta > RAMP_STEP) delta = RAMP_STEP;
                                if (delta < -RAMP_STEP) delta = -RAMP_STEP;
                                m_duty[ch] += delta;
                            end
                        end
                        BRAKE: begin
                            if (m_tdir[ch] == m_adir[ch]) begin
                                m_mode[ch] = DRIVE;
                            end else if (m_duty[ch] == 0) begin
                                m_mode[ch] = GAP;
                                m_gap[ch]  = DEAD_CYCLES;
                            end else if (tick) begin
                                m_duty[ch] = (m_duty[ch] > RAMP_STEP) ? m_duty[ch] - RAMP_STEP : 0;
                            end
                        end
                        default: begin
                            m_gap[ch]--;
                            if (m_gap[ch] == 0) begin
                                if (m_tgt[ch] == 0) begin
                                    m_mode[ch] = OFF;
                                end else begin
                                    m_adir[ch] = m_tdir[ch];
                                    m_mode[ch] = DRIVE;
                                end
                            end
                        end
                    endcase
                    if (cmd_valid) begin
                        spd        = int'(speed_cmd[ch*DUTY_W +: DUTY_W]);
                        m_tgt[ch]  = (spd > MAX_POSITION) ? MAX_POSITION : spd;
                        m_tdir[ch] = int'(dir_cmd[ch]);
                    end
                end
            end
            if (m_r2 != m_db) begin
                m_run++;
                if (m_run >= DEBOUNCE_CYCLES) begin
                    m_db  = m_r2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_r2 = m_r1;
            m_r1 = reed_in;
            m_since++;
        end
        m_pwm = m_since % PWM_PERIOD;
        e = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e[7 + ch] = (m_mode[ch] == DRIVE || m_mode[ch] == BRAKE) && (m_adir[ch] == 1);
            e[5 + ch] = (m_mode[ch] == DRIVE || m_mode[ch] == BRAKE) && (m_adir[ch] == 0);
            e[3 + ch] = m_en[ch];
            e[1 + ch] = (m_mode[ch] == BRAKE) || (m_mode[ch] == GAP) ||
                        (m_mode[ch] == DRIVE && m_duty[ch] != m_tgt[ch]);
        end
        e[0] = m_db;
        exp_q.push_back(e);
    endtask

    // Reference model runs on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            stepModel();
        end
    end

    // Monitor: compare the DUT against the oldest expected vector.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("scoreboard", 32'({motor_in1, motor_in2, motor_en, busy, estop_active}), 32'(e));
            end
        end
    end

    // Channel 0 on-time per PWM period, closed when the model phase wraps.
    initial begin
        forever begin
            @(negedge clk);
            win_acc += int'(motor_en[0]);
            if (m_pwm == 0) begin
                win_q.push_back(win_acc);
                win_acc = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by a randomized phase.
    initial begin
        int cnt;
        int cnt1;
        int idx;
        int k;
        int n;
        int any;
        int reed_hold;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_outputs", 32'({motor_in1, motor_in2, motor_en, busy, estop_active}), 32'd0);

        countEn(0, 100, cnt);
        countEn(1, 1, cnt1);
        checkOutput("idle_en_quiet", 32'(cnt + cnt1), 32'd0);

        $display("[TB] ramp ch0 to full scale forward");
        applyStimulus(10, 1, 0, 0);
        win_q.delete();
        repeat (180) @(negedge clk);
        idx = 0;
        while (idx < win_q.size() && win_q[idx] == 0) idx++;
        for (int w = 0; w < 5; w++) begin
            checkOutput($sformatf("ramp_window%0d", w),
                        32'((idx + w < win_q.size()) ? win_q[idx + w] : -1), 32'(4 * (w + 1)));
        end

        $display("[TB] reverse ch0");
        applyStimulus(10, 0, 0, 0);
        k = 0;
        while (k < 300 && (motor_in1[0] || motor_in2[0])) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reach_dead", 32'(k < 300), 32'd1);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (motor_in1[0] || motor_in2[0]) break;
            n++;
        end
        checkOutput("dead_length", 32'(n), 32'(DEAD_CYCLES));
        checkOutput("reverse_pins", 32'({motor_in1[0], motor_in2[0]}), 32'b01);

        $display("[TB] clamp over-range command on ch1");
        applyStimulus(10, 0, 15, 1);
        repeat (140) @(negedge clk);
        countEn(1, PWM_PERIOD, cnt);
        checkOutput("clamp_full_on_ch1", 32'(cnt), 32'(PWM_PERIOD));
        countEn(0, PWM_PERIOD, cnt);
        checkOutput("reverse_full_on_ch0", 32'(cnt), 32'(PWM_PERIOD));

        $display("[TB] short reed pulse");
        reed_in = 1'b1;
        repeat (3) @(negedge clk);
        reed_in = 1'b0;
        any = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            any |= int'(estop_active);
        end
        checkOutput("short_pulse_ignored", 32'(any), 32'd0);

        $display("[TB] held reed");
        reed_in = 1'b1;
        k = 0;
        while (k < 20 && !estop_active) begin
            @(negedge clk);
            k++;
        end
        checkOutput("estop_latency", 32'(k), 32'(2 + DEBOUNCE_CYCLES));
        @(negedge clk);
        checkOutput("estop_outputs_off", 32'({motor_in1, motor_in2, motor_en}), 32'd0);
        applyStimulus(8, 1, 8, 1);
        repeat (30) @(negedge clk);
        checkOutput("estop_cmd_ignored", 32'({motor_in1, motor_in2, motor_en}), 32'd0);
        reed_in = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("release_stays_idle", 32'({motor_in1, motor_in2, motor_en, busy, estop_active}), 32'd0);

        $display("[TB] reset mid-ramp");
        applyStimulus(10, 1, 10, 0);
        repeat (75) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_mid_ramp", 32'({motor_in1, motor_in2, motor_en, busy, estop_active}), 32'd0);
        applyStimulus(6, 0, 4, 1);
        repeat (200) @(negedge clk);

        $display("[TB] random phase");
        reed_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                speed_cmd = 8'($urandom);
                dir_cmd   = 2'($urandom);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (reed_hold > 0) begin
                reed_hold--;
                if (reed_hold == 0) reed_in = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                reed_in   = 1'b1;
                reed_hold = $urandom_range(2, 40);
            end
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        reed_in   = 1'b0;
        rst       = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
